axi_lite_reg_responder: RTL and testbench
=========================================

// Module: axi_lite_reg_responder
// PURPOSE
// - AXI4-Lite slave (responder) exposing NUM_REGS 32-bit registers to the fabric.
// - Completes single-beat AXI-Lite master transactions: AW+W->B writes, AR->R reads.
// - Registers listed in RO_MASK are read-only status registers sourced from sts_i.
// - All others are RW control registers driven on reg_o, with per-register access strobes.
// PARAMETERS
// - P_DATA_WIDTH  32          AXI data width; fixed at 32, bytes = 4.
// - P_ADDR_WIDTH  32          AXI address width.
// - P_NUM_REGS    8           number of registers, 1..256; reg i at byte offset 4*i.
// - P_RO_MASK     8'h01       bit i=1: reg i is read-only (returns sts_i slice).
// - P_RST_VAL     '0          flat NUM_REGS*32 reset value of the RW registers.
// PORTS
// - ACLK          in   1       clock
// - ARESETn       in   1       reset, asynchronous, active-low
// - S_AXI_AWADDR  in   AW      write address
// - S_AXI_AWPROT  in   3       ignored
// - S_AXI_AWVALID in   1       / S_AXI_AWREADY out 1
// - S_AXI_WDATA   in   32      / S_AXI_WSTRB in 4 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1
// - S_AXI_BRESP   out  2       / S_AXI_BVALID out 1 / S_AXI_BREADY in 1
// - S_AXI_ARADDR  in   AW      / S_AXI_ARPROT in 3 (ignored) / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1
// - S_AXI_RDATA   out  32      / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1
// - reg_o         out  N*32    RW register contents; RO slots read 0
// - sts_i         in   N*32    status inputs for RO registers; other slots unused
// - wr_pulse_o    out  N       1-cycle strobe: reg i written (RW or RO target)
// - rd_pulse_o    out  N       1-cycle strobe: reg i read
// BEHAVIOUR
// - Reset (async, ARESETn low): all READY/VALID=0, BRESP=RRESP=0, RDATA=0, pulses=0.
//   RW regs=P_RST_VAL.
// - rst_done flop goes 1 on the first edge after deassert.
// - All READYs are 0 until rst_done=1.
// - Decode: idx = ADDR[2 +: 8]; ADDR[1:0] ignored.
// - Address is out-of-range if ADDR >= 4*P_NUM_REGS -> RESP=SLVERR (2'b10); otherwise OKAY (2'b00).
// - Write channel, AW and W independent, either order or same cycle:
//   - AWREADY = rst_done & !aw_held & !BVALID;  WREADY = rst_done & !w_held & !BVALID.
//   - AW handshake latches AWADDR (aw_held=1); W handshake latches WDATA/WSTRB (w_held=1).
//   - Commit edge = edge where both are held or completing: RW in-range reg gets byte
//     lanes with WSTRB[b]=1.
//   - On commit: BVALID=1 with BRESP; wr_pulse_o[idx]=1 for 1 cycle (in-range only).
//     aw_held and w_held clear.
//   - RO or out-of-range write: no register change. RO -> OKAY, out-of-range -> SLVERR.
//   - WSTRB=0: no change, OKAY, wr_pulse still fires.
//   - BVALID/BRESP stable until BREADY; BVALID clears on the BVALID&BREADY edge.
//     The next AW/W is accepted from the following cycle.
// - Read channel:
//   - ARREADY = rst_done & !RVALID.
//   - AR handshake at edge N: RDATA/RRESP/RVALID registered at edge N.
//     rd_pulse_o[idx]=1 for 1 cycle (in-range).
//   - RDATA = RO ? sts_i slice sampled at edge N : RW reg value before any same-edge write.
//     Out-of-range -> RDATA=0, SLVERR.
//   - RDATA/RRESP stable while RVALID & !RREADY; RVALID clears on the handshake edge.
//   - Peak rate: 1 read per 2 cycles; writes 1 per 2 cycles with BREADY tied 1.
// - Simultaneous read and write of the same reg on one edge: read returns old value;
//   write still commits.
// - Reset mid-transaction: held AW/W and pending B/R are dropped.
// - No response is issued for an abandoned transaction.
// STRUCTURE
// - axi_lite_pkg:
//   - localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
//   - typedef axi_resp_t = logic [1:0].
//   - function f_in_range(addr, num_regs).
// - Sub-module axi_lite_aw_w_join:
//   - AW/W holding flops, AWREADY/WREADY generation, commit strobe, B channel.
//   - The top module keeps the register array, the read path and the pulses.
// TESTING
// 1. Reset then idle: all READY=0 in the first cycle; from cycle 2 AWREADY=WREADY=ARREADY=1.
//    reg_o=P_RST_VAL.
// 2. Write 0x4 data 0x6 WSTRB=F, then read 0x4: BRESP=00, RDATA=0x00000006, RRESP=00.
//    wr_pulse_o[1] and rd_pulse_o[1] each fire once.
// 3. W two cycles before AW, WSTRB=4'b0010, data 0xAABBCCDD onto reg2=0x11223344:
//    BVALID only after AW; reg2=0x1122CC44.
// 4. Write and read 0x20 with P_NUM_REGS=8: BRESP=10, RRESP=10, RDATA=0, no pulses.
//    No reg changes.
// 5. Write reg0 (RO) with sts_i[31:0]=0xCAFE0001: BRESP=00 and reg0 unchanged.
//    Read returns 0xCAFE0001.
// 6. BREADY/RREADY held 0 for 5 cycles: BVALID/RVALID and data stable, AW/W/ARREADY=0.
//    Assert ARESETn=0 mid-hold: all VALIDs drop immediately.

Source files
------------

// File: rtl/axi_lite_reg_responder_pkg.sv
// Shared AXI4-Lite response codes and address-decode helper for the register responder.
package axi_lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    // An address hits a register when it falls below 4 bytes * register count.
    function automatic logic f_in_range(input logic [31:0] addr, input int unsigned num_regs);
        logic [33:0] limit_s;
        limit_s = 34'(num_regs) * 34'd4;
        return ({2'b00, addr} < limit_s);
    endfunction

endpackage

// File: rtl/axi_lite_reg_responder_if.sv
// AXI4-Lite bus bundle between a fabric master and the register responder.
interface axi_lite_reg_responder_if #(
    parameter int P_ADDR_WIDTH = 32
);
    logic [P_ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [31:0]             S_AXI_WDATA;
    logic [3:0]              S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [P_ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [31:0]             S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi_lite_reg_responder_aw_w_join.sv
// Joins independently arriving AW and W beats into one commit strobe and owns the B channel.
module axi_lite_aw_w_join
    import axi_lite_pkg::*;
#(
    parameter int P_NUM_REGS = 8
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        rst_done_i,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output axi_resp_t   bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic        commit_o,
    output logic [31:0] commit_addr_o,
    output logic [31:0] commit_data_o,
    output logic [3:0]  commit_strb_o
);

    logic        aw_held_r;
    logic        w_held_r;
    logic        bvalid_r;
    axi_resp_t   bresp_r;
    logic [31:0] awaddr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        aw_hs_s;
    logic        w_hs_s;

    // Ready generation and commit detection; a beat arriving now bypasses its holding flop.
    always_comb begin
        awready_o     = rst_done_i & ~aw_held_r & ~bvalid_r;
        wready_o      = rst_done_i & ~w_held_r & ~bvalid_r;
        aw_hs_s       = awvalid_i & awready_o;
        w_hs_s        = wvalid_i & wready_o;
        commit_o      = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
        commit_addr_o = aw_held_r ? awaddr_r : awaddr_i;
        commit_data_o = w_held_r ? wdata_r : wdata_i;
        commit_strb_o = w_held_r ? wstrb_r : wstrb_i;
        bresp_o       = bresp_r;
        bvalid_o      = bvalid_r;
    end

    // Holding flops and write response; readies are low while B is pending, so commit never overlaps it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awaddr_r  <= 32'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
        end else if (commit_o) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= f_in_range(commit_addr_o, P_NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                awaddr_r  <= awaddr_i;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= wdata_i;
                wstrb_r  <= wstrb_i;
            end
            if (bvalid_r && bready_i) begin
                bvalid_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register responder: RW control registers on reg_o, RO status registers from sts_i.
module axi_lite_reg_responder
    import axi_lite_pkg::*;
#(
    parameter int                          P_DATA_WIDTH = 32,
    parameter int                          P_ADDR_WIDTH = 32,
    parameter int                          P_NUM_REGS   = 8,
    parameter logic [P_NUM_REGS-1:0]       P_RO_MASK    = P_NUM_REGS'(8'h01),
    parameter logic [P_NUM_REGS*32-1:0]    P_RST_VAL    = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axi_lite_reg_responder_if.slave      s_axi,
    output logic [P_NUM_REGS*32-1:0]     reg_o,
    input  logic [P_NUM_REGS*32-1:0]     sts_i,
    output logic [P_NUM_REGS-1:0]        wr_pulse_o,
    output logic [P_NUM_REGS-1:0]        rd_pulse_o
);

    logic                    rst_done_r;
    logic [P_DATA_WIDTH-1:0] reg_r [P_NUM_REGS];
    logic [P_NUM_REGS-1:0]   wr_pulse_r;
    logic [P_NUM_REGS-1:0]   rd_pulse_r;
    logic                    rvalid_r;
    axi_resp_t               rresp_r;
    logic [P_DATA_WIDTH-1:0] rdata_r;

    logic [P_ADDR_WIDTH-1:0] awaddr_s;
    logic [P_ADDR_WIDTH-1:0] araddr_s;
    logic [31:0]             ar_addr32_s;
    logic [7:0]              ar_idx_s;
    logic                    ar_in_range_s;
    logic                    arready_s;
    logic                    ar_hs_s;
    logic [P_DATA_WIDTH-1:0] rd_data_s;
    logic [P_NUM_REGS-1:0]   rd_onehot_s;

    logic                    commit_s;
    logic [31:0]             commit_addr_s;
    logic [31:0]             commit_data_s;
    logic [3:0]              commit_strb_s;
    logic [7:0]              commit_idx_s;
    logic                    wr_in_range_s;
    logic [P_NUM_REGS-1:0]   wr_onehot_s;
    logic                    unused_ok_s;

    assign awaddr_s    = s_axi.S_AXI_AWADDR;
    assign araddr_s    = s_axi.S_AXI_ARADDR;
    assign unused_ok_s = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // READYs stay low until the first clock edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    axi_lite_aw_w_join #(
        .P_NUM_REGS (P_NUM_REGS)
    ) u_aw_w_join (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .rst_done_i    (rst_done_r),
        .awaddr_i      (32'(awaddr_s)),
        .awvalid_i     (s_axi.S_AXI_AWVALID),
        .awready_o     (s_axi.S_AXI_AWREADY),
        .wdata_i       (s_axi.S_AXI_WDATA),
        .wstrb_i       (s_axi.S_AXI_WSTRB),
        .wvalid_i      (s_axi.S_AXI_WVALID),
        .wready_o      (s_axi.S_AXI_WREADY),
        .bresp_o       (s_axi.S_AXI_BRESP),
        .bvalid_o      (s_axi.S_AXI_BVALID),
        .bready_i      (s_axi.S_AXI_BREADY),
        .commit_o      (commit_s),
        .commit_addr_o (commit_addr_s),
        .commit_data_o (commit_data_s),
        .commit_strb_o (commit_strb_s)
    );

    // Decode both channels into one-hot register selects; the read mux is an OR of gated slots.
    always_comb begin
        commit_idx_s  = commit_addr_s[9:2];
        wr_in_range_s = f_in_range(commit_addr_s, P_NUM_REGS);
        ar_addr32_s   = 32'(araddr_s);
        ar_idx_s      = ar_addr32_s[9:2];
        ar_in_range_s = f_in_range(ar_addr32_s, P_NUM_REGS);
        arready_s     = rst_done_r & ~rvalid_r;
        ar_hs_s       = s_axi.S_AXI_ARVALID & arready_s;
        rd_data_s     = '0;
        wr_onehot_s   = '0;
        rd_onehot_s   = '0;
        for (int i = 0; i < P_NUM_REGS; i++) begin
            wr_onehot_s[i] = commit_s & wr_in_range_s & (commit_idx_s == 8'(i));
            rd_onehot_s[i] = ar_in_range_s & (ar_idx_s == 8'(i));
            rd_data_s      = rd_data_s | (rd_onehot_s[i] ?
                             (P_RO_MASK[i] ? sts_i[32*i +: 32] : reg_r[i]) : 32'd0);
        end
    end

    // Register array with byte-lane writes; read-only slots are never written.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < P_NUM_REGS; i++) begin
                reg_r[i] <= P_RST_VAL[32*i +: 32];
            end
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= wr_onehot_s;
            for (int i = 0; i < P_NUM_REGS; i++) begin
                if (wr_onehot_s[i] && !P_RO_MASK[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (commit_strb_s[b]) begin
                            reg_r[i][8*b +: 8] <= commit_data_s[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: data captured on the AR handshake edge holds until RREADY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_r   <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= '0;
            rd_pulse_r <= '0;
        end else if (ar_hs_s) begin
            rvalid_r   <= 1'b1;
            rresp_r    <= ar_in_range_s ? RESP_OKAY : RESP_SLVERR;
            rdata_r    <= rd_data_s;
            rd_pulse_r <= rd_onehot_s;
        end else begin
            rd_pulse_r <= '0;
            if (rvalid_r && s_axi.S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_ARREADY = arready_s;
    assign s_axi.S_AXI_RVALID  = rvalid_r;
    assign s_axi.S_AXI_RRESP   = rresp_r;
    assign s_axi.S_AXI_RDATA   = rdata_r;
    assign wr_pulse_o          = wr_pulse_r;
    assign rd_pulse_o          = rd_pulse_r;

    for (genvar g = 0; g < P_NUM_REGS; g++) begin : g_reg_out
        assign reg_o[32*g +: 32] = P_RO_MASK[g] ? 32'd0 : reg_r[g];
    end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Directed bench for axi_lite_reg_responder (8 registers, reg0 read-only) with hand-computed expectations.
module tb_axi_lite_reg_responder;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [255:0] reg_o;
    logic [255:0] sts_i;
    logic [7:0]   wr_pulse_o;
    logic [7:0]   rd_pulse_o;

    int n_cmp = 0;
    int n_mis = 0;
    int wr_cnt [8] = '{default: 0};
    int rd_cnt [8] = '{default: 0};

    logic [255:0] exp_regs;
    logic [1:0]   resp;
    logic [31:0]  rdata;
    int           wr_tot0;
    int           rd_tot0;

    axi_lite_reg_responder_if #(.P_ADDR_WIDTH(32)) bus ();

    axi_lite_reg_responder dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .s_axi      (bus.slave),
        .reg_o      (reg_o),
        .sts_i      (sts_i),
        .wr_pulse_o (wr_pulse_o),
        .rd_pulse_o (rd_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        for (int i = 0; i < 8; i++) begin
            wr_cnt[i] <= wr_cnt[i] + int'(wr_pulse_o[i]);
            rd_cnt[i] <= rd_cnt[i] + int'(rd_pulse_o[i]);
        end
    end

    task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sum_cnt(input bit rd);
        int s = 0;
        for (int i = 0; i < 8; i++) s += rd ? rd_cnt[i] : wr_cnt[i];
        return s;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit take_b, output logic [1:0] bresp);
        bit aw_acc, w_acc;
        int cyc = 0;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && cyc < 20) begin
            aw_acc = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_acc  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_acc) bus.S_AXI_AWVALID = 1'b0;
            if (w_acc)  bus.S_AXI_WVALID  = 1'b0;
            cyc++;
        end
        chk_eq("aw_w_accepted", {bus.S_AXI_AWVALID, bus.S_AXI_WVALID}, 2'b00);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bresp = 2'bxx;
        if (take_b) begin
            cyc = 0;
            while (!bus.S_AXI_BVALID && cyc < 20) begin
                @(posedge ACLK); #1;
                cyc++;
            end
            chk_eq("bvalid_seen", bus.S_AXI_BVALID, 1'b1);
            bresp = bus.S_AXI_BRESP;
            bus.S_AXI_BREADY = 1'b1;
            @(posedge ACLK); #1;
            bus.S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] rresp);
        bit ar_acc = 1'b0;
        int cyc = 0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        while (!ar_acc && cyc < 20) begin
            ar_acc = bus.S_AXI_ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        chk_eq("ar_accepted", ar_acc, 1'b1);
        cyc = 0;
        while (!bus.S_AXI_RVALID && cyc < 20) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        chk_eq("rvalid_seen", bus.S_AXI_RVALID, 1'b1);
        data  = bus.S_AXI_RDATA;
        rresp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        ARESETn           = 1'b0;
        sts_i             = 256'd0;
        bus.S_AXI_AWADDR  = 32'd0;
        bus.S_AXI_AWPROT  = 3'd0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = 32'd0;
        bus.S_AXI_WSTRB   = 4'd0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = 32'd0;
        bus.S_AXI_ARPROT  = 3'd0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        exp_regs          = 256'd0;

        // 1. reset and the one idle cycle before READYs rise
        repeat (2) @(posedge ACLK);
        #1;
        chk_eq("rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 38'd0);
        chk_eq("rst_pulses", {wr_pulse_o, rd_pulse_o}, 16'd0);
        ARESETn = 1'b1;
        chk_eq("first_cycle_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        chk_eq("cycle2_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        chk_eq("rst_reg_o", reg_o, 256'd0);

        // 2. basic write then read of reg1
        axi_write(32'h4, 32'h6, 4'hF, 1'b1, resp);
        chk_eq("t2_bresp", resp, 2'b00);
        axi_read(32'h4, rdata, resp);
        chk_eq("t2_rdata", rdata, 32'h0000_0006);
        chk_eq("t2_rresp", resp, 2'b00);
        chk_eq("t2_wr_pulse1", wr_cnt[1], 1);
        chk_eq("t2_rd_pulse1", rd_cnt[1], 1);
        exp_regs[63:32] = 32'h6;
        chk_eq("t2_reg_o", reg_o, exp_regs);

        // 3. W beat two cycles ahead of AW, single byte lane
        axi_write(32'h8, 32'h1122_3344, 4'hF, 1'b1, resp);
        bus.S_AXI_WDATA  = 32'hAABB_CCDD;
        bus.S_AXI_WSTRB  = 4'b0010;
        bus.S_AXI_WVALID = 1'b1;
        chk_eq("t3_wready", bus.S_AXI_WREADY, 1'b1);
        @(posedge ACLK); #1;
        bus.S_AXI_WVALID = 1'b0;
        chk_eq("t3_w_held_wready", bus.S_AXI_WREADY, 1'b0);
        @(posedge ACLK); #1;
        chk_eq("t3_no_bvalid_before_aw", bus.S_AXI_BVALID, 1'b0);
        bus.S_AXI_AWADDR  = 32'h8;
        bus.S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        chk_eq("t3_bvalid_bresp", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
        exp_regs[95:64] = 32'h1122_CC44;
        chk_eq("t3_reg2", reg_o, exp_regs);
        bus.S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_BREADY = 1'b0;

        // 4. out-of-range write and read at 0x20
        wr_tot0 = sum_cnt(1'b0);
        rd_tot0 = sum_cnt(1'b1);
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, resp);
        chk_eq("t4_bresp", resp, 2'b10);
        axi_read(32'h20, rdata, resp);
        chk_eq("t4_rdata", rdata, 32'd0);
        chk_eq("t4_rresp", resp, 2'b10);
        chk_eq("t4_no_pulses", {sum_cnt(1'b0), sum_cnt(1'b1)}, {wr_tot0, rd_tot0});
        chk_eq("t4_reg_o", reg_o, exp_regs);

        // 5. write to RO reg0 and read back the status slice
        sts_i[31:0] = 32'hCAFE_0001;
        axi_write(32'h0, 32'h1234_5678, 4'hF, 1'b1, resp);
        chk_eq("t5_bresp", resp, 2'b00);
        chk_eq("t5_reg_o", reg_o, exp_regs);
        axi_read(32'h0, rdata, resp);
        chk_eq("t5_rdata", rdata, 32'hCAFE_0001);
        chk_eq("t5_pulses0", {wr_cnt[0], rd_cnt[0]}, {32'd1, 32'd1});

        // WSTRB=0: no data change, OKAY, pulse still fires
        axi_write(32'h4, 32'hFFFF_FFFF, 4'h0, 1'b1, resp);
        chk_eq("strb0_bresp", resp, 2'b00);
        chk_eq("strb0_reg_o", reg_o, exp_regs);
        chk_eq("strb0_wr_pulse1", wr_cnt[1], 2);

        // same-edge read and write of reg1: read sees the old value
        bus.S_AXI_AWADDR  = 32'h4;
        bus.S_AXI_WDATA   = 32'h77;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_ARADDR  = 32'h4;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        chk_eq("rw_same_rdata", {bus.S_AXI_RVALID, bus.S_AXI_RDATA}, {1'b1, 32'h6});
        exp_regs[63:32] = 32'h77;
        chk_eq("rw_same_commit", {bus.S_AXI_BVALID, reg_o}, {1'b1, exp_regs});
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        // 6. back-pressure on B and R, then reset while both are pending
        axi_write(32'hC, 32'h5A5A_5A5A, 4'hF, 1'b0, resp);
        bus.S_AXI_ARADDR  = 32'h4;
        bus.S_AXI_ARVALID = 1'b1;
        chk_eq("t6_arready", bus.S_AXI_ARREADY, 1'b1);
        @(posedge ACLK); #1;
        bus.S_AXI_ARVALID = 1'b0;
        exp_regs[127:96] = 32'h5A5A_5A5A;
        for (int c = 0; c < 5; c++) begin
            chk_eq("t6_b_hold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
            chk_eq("t6_r_hold", {bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, {1'b1, 2'b00, 32'h77});
            chk_eq("t6_readies_low", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
            @(posedge ACLK); #1;
        end
        chk_eq("t6_reg_o", reg_o, exp_regs);
        #2;
        ARESETn = 1'b0;
        #1;
        chk_eq("t6_rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        chk_eq("t6_rst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        chk_eq("t6_post_rst", {bus.S_AXI_AWREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID, reg_o}, {3'b100, 256'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
